// File: rtl/snac_pad_pkg.sv
// Shared types and constants for the SNAC SNES-pad encoder: FSM states,
// SNES serial bit order, Pocket cont_key bit positions and packing helpers.
package snac_pad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    LOW,
    HIGH,
    DONE
  } state_t;

  // SNES serial bit order (k = 0 is shifted out first); ID0..ID3 follow at 12..15
  localparam int unsigned SNES_B      = 0;
  localparam int unsigned SNES_Y      = 1;
  localparam int unsigned SNES_SELECT = 2;
  localparam int unsigned SNES_START  = 3;
  localparam int unsigned SNES_UP     = 4;
  localparam int unsigned SNES_DOWN   = 5;
  localparam int unsigned SNES_LEFT   = 6;
  localparam int unsigned SNES_RIGHT  = 7;
  localparam int unsigned SNES_A      = 8;
  localparam int unsigned SNES_X      = 9;
  localparam int unsigned SNES_L      = 10;
  localparam int unsigned SNES_R      = 11;
  localparam int unsigned SNES_BUTTONS = 12;
  localparam int unsigned SNES_BITS    = 16;

  localparam logic [3:0] PAD_TYPE_SNAC = 4'h3;
  localparam logic [7:0] JOY_CENTER    = 8'h80;

  // cont_key bit positions
  localparam int unsigned KEY_UP     = 0;
  localparam int unsigned KEY_DOWN   = 1;
  localparam int unsigned KEY_LEFT   = 2;
  localparam int unsigned KEY_RIGHT  = 3;
  localparam int unsigned KEY_A      = 4;
  localparam int unsigned KEY_B      = 5;
  localparam int unsigned KEY_X      = 6;
  localparam int unsigned KEY_Y      = 7;
  localparam int unsigned KEY_L1     = 8;
  localparam int unsigned KEY_R1     = 9;
  localparam int unsigned KEY_SELECT = 14;
  localparam int unsigned KEY_START  = 15;

  // p is active-high (1 = pressed), indexed by SNES bit order
  function automatic logic [31:0] pack_key(input logic [SNES_BUTTONS-1:0] p);
    logic [31:0] k;
    k = '0;
    k[KEY_UP]     = p[SNES_UP];
    k[KEY_DOWN]   = p[SNES_DOWN];
    k[KEY_LEFT]   = p[SNES_LEFT];
    k[KEY_RIGHT]  = p[SNES_RIGHT];
    k[KEY_A]      = p[SNES_A];
    k[KEY_B]      = p[SNES_B];
    k[KEY_X]      = p[SNES_X];
    k[KEY_Y]      = p[SNES_Y];
    k[KEY_L1]     = p[SNES_L];
    k[KEY_R1]     = p[SNES_R];
    k[KEY_SELECT] = p[SNES_SELECT];
    k[KEY_START]  = p[SNES_START];
    k[31:28]      = PAD_TYPE_SNAC;
    return k;
  endfunction

  // Digital direction pair to an analog axis byte; opposing presses cancel
  function automatic logic [7:0] axis_value(input logic neg, input logic pos);
    if (neg && !pos)      return 8'h00;
    else if (pos && !neg) return 8'hFF;
    else                  return JOY_CENTER;
  endfunction

endpackage

// File: rtl/snac_pad_encoder_sync.sv
// Two-flop synchronizer for the asynchronous pad data pin; resets to 1
// (released) so a pad that is not yet driven reads as no buttons pressed.
module snac_sync (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/snac_pad_encoder.sv
// Polls an SNES pad on the SNAC port and publishes Pocket cont_key/cont_joy words.
// Optional macro SNAC_PAD_ANALOG_EN: cont_joy mirrors the D-pad on lx/ly.
module snac_pad_encoder
  import snac_pad_pkg::*;
#(
  parameter logic [15:0] HALF_DIV = 16'd400,
  parameter logic [23:0] POLL_DIV = 24'd1_237_500
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        pad_data,
  output logic        pad_latch,
  output logic        pad_clk,
  output logic [31:0] cont_key,
  output logic [31:0] cont_joy,
  output logic        frame_strobe
);

  localparam logic [16:0] LATCH_LAST = {HALF_DIV, 1'b0} - 17'd1;
  localparam logic [16:0] HALF_LAST  = {1'b0, HALF_DIV} - 17'd1;
  localparam logic [31:0] JOY_IDLE   = {4{JOY_CENTER}};

  state_t                  state;
  logic [16:0]             hcnt;
  logic [3:0]              bit_idx;
  logic [SNES_BUTTONS-1:0] shift;
  logic [23:0]             poll_cnt;
  logic                    data_s;
  logic                    poll_wrap_c;
  logic [SNES_BUTTONS-1:0] pressed_c;
  logic [31:0]             key_c;
  logic [31:0]             joy_c;

  snac_sync u_sync (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .d       (pad_data),
    .q       (data_s)
  );

  assign poll_wrap_c = (poll_cnt == POLL_DIV - 24'd1);

  // Frame payload from the captured (active-low) button bits
  always_comb begin
    pressed_c = ~shift;
    key_c     = pack_key(pressed_c);
`ifdef SNAC_PAD_ANALOG_EN
    joy_c = {JOY_CENTER, JOY_CENTER,
             axis_value(pressed_c[SNES_UP], pressed_c[SNES_DOWN]),
             axis_value(pressed_c[SNES_LEFT], pressed_c[SNES_RIGHT])};
`else
    joy_c = JOY_IDLE;
`endif
  end

  // Poll timer and frame sequencer; pad pins track the state they belong to
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      hcnt         <= '0;
      bit_idx      <= '0;
      shift        <= '1;
      poll_cnt     <= '0;
      pad_latch    <= 1'b0;
      pad_clk      <= 1'b1;
      cont_key     <= '0;
      cont_joy     <= JOY_IDLE;
      frame_strobe <= 1'b0;
    end else begin
      frame_strobe <= 1'b0;
      poll_cnt     <= poll_wrap_c ? 24'd0 : poll_cnt + 24'd1;

      case (state)
        IDLE: begin
          if (poll_wrap_c && enable) begin
            state     <= LATCH;
            pad_latch <= 1'b1;
            hcnt      <= '0;
          end
        end

        LATCH: begin
          if (hcnt == LATCH_LAST) begin
            state     <= LOW;
            pad_latch <= 1'b0;
            pad_clk   <= 1'b0;
            hcnt      <= '0;
            bit_idx   <= '0;
          end else begin
            hcnt <= hcnt + 17'd1;
          end
        end

        LOW: begin
          if (hcnt == HALF_LAST) begin
            // ID bits (12..15) are clocked out by the pad but not kept
            if (bit_idx < 4'(SNES_BUTTONS)) shift[bit_idx] <= data_s;
            state   <= HIGH;
            pad_clk <= 1'b1;
            hcnt    <= '0;
          end else begin
            hcnt <= hcnt + 17'd1;
          end
        end

        HIGH: begin
          if (hcnt == HALF_LAST) begin
            hcnt <= '0;
            if (bit_idx == 4'(SNES_BITS - 1)) begin
              state <= DONE;
            end else begin
              bit_idx <= bit_idx + 4'd1;
              state   <= LOW;
              pad_clk <= 1'b0;
            end
          end else begin
            hcnt <= hcnt + 17'd1;
          end
        end

        DONE: begin
          cont_key     <= key_c;
          cont_joy     <= joy_c;
          frame_strobe <= 1'b1;
          state        <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snac_pad_encoder.sv
// Bench for snac_pad_encoder: SNES pad model, timeline reference model, per-cycle compare.
`timescale 1ns/1ps
module tb_snac_pad_encoder;

  localparam int PD         = 200;
  localparam int STROBE_POS = 137;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable  = 1'b1;
  logic        pad_data;
  logic        pad_latch, pad_clk, frame_strobe;
  logic [31:0] cont_key, cont_joy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  snac_pad_encoder #(.HALF_DIV(16'd4), .POLL_DIV(24'd200)) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .enable       (enable),
    .pad_data     (pad_data),
    .pad_latch    (pad_latch),
    .pad_clk      (pad_clk),
    .cont_key     (cont_key),
    .cont_joy     (cont_joy),
    .frame_strobe (frame_strobe)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // SNES pad: latch loads buttons and presents bit 0; each pad_clk rise advances
  logic [15:0] next_pressed = 16'h0000;
  logic [15:0] pressed      = 16'h0000;
  int          idx          = 0;
  always @(posedge pad_latch or posedge pad_clk) begin
    if (pad_latch) begin
      pressed = next_pressed;
      idx     = 0;
    end else if (idx < 16) begin
      idx++;
    end
  end
  assign pad_data = (idx < 16) ? ~pressed[4'(idx)] : 1'b1;

  function automatic logic [31:0] model_key(input logic [15:0] p);
    return {4'h3, 12'h000, p[3], p[2], 4'h0, p[11], p[10], p[1], p[9], p[0], p[8],
            p[7], p[6], p[5], p[4]};
  endfunction

  function automatic logic [31:0] model_joy(input logic [15:0] p);
    logic [7:0] lx, ly;
    lx = 8'h80;
    ly = 8'h80;
`ifdef SNAC_PAD_ANALOG_EN
    if (p[6] != p[7]) lx = p[6] ? 8'h00 : 8'hFF;
    if (p[4] != p[5]) ly = p[4] ? 8'h00 : 8'hFF;
`endif
    return {8'h80, 8'h80, ly, lx};
  endfunction

  // Reference timeline: pos = cycles since latch rise (-1 when no frame active)
  int          tick    = 0;
  int          pos     = -1;
  logic [31:0] exp_key = 32'h0;
  logic [31:0] exp_joy = 32'h8080_8080;
  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tick    = 0;
      pos     = -1;
      exp_key = 32'h0;
      exp_joy = 32'h8080_8080;
    end else begin
      bit start;
      start = (tick == PD - 1) && enable && (pos < 0 || pos >= STROBE_POS);
      if (start) pos = 0;
      else if (pos >= 0) begin
        pos++;
        if (pos > STROBE_POS) pos = -1;
      end
      if (pos == STROBE_POS) begin
        exp_key = model_key(pressed);
        exp_joy = model_joy(pressed);
      end
      tick = (tick == PD - 1) ? 0 : tick + 1;
    end
  end

  always @(negedge clk_sys) begin
    check("pad_latch", 32'(pad_latch), 32'(pos >= 0 && pos < 8));
    check("pad_clk", 32'(pad_clk), 32'(!(pos >= 8 && pos < 136 && ((pos - 8) % 8) < 4)));
    check("frame_strobe", 32'(frame_strobe), 32'(pos == STROBE_POS));
    check("cont_key", cont_key, exp_key);
    check("cont_joy", cont_joy, exp_joy);
  end

  // Literal frame-shape pins, independent of the timeline model
  bit prev_latch = 1'b0, prev_clk = 1'b1, in_frame = 1'b0;
  int lat_cyc = 0, falls = 0, low_len = 0, lat_len = 0;
  always @(negedge clk_sys) begin
    if (!reset_n) begin
      in_frame = 1'b0;
      falls    = 0;
      low_len  = 0;
      lat_len  = 0;
    end else begin
      if (pad_latch && !prev_latch) begin
        in_frame = 1'b1;
        lat_cyc  = cyc;
        falls    = 0;
        lat_len  = 0;
      end
      if (pad_latch) lat_len++;
      if (!pad_latch && prev_latch) check("latch_width", 32'(lat_len), 32'd8);
      if (!pad_clk) low_len++;
      if (!pad_clk && prev_clk) falls++;
      if (pad_clk && !prev_clk) begin
        check("clk_low_width", 32'(low_len), 32'd4);
        low_len = 0;
      end
      if (frame_strobe && in_frame) begin
        check("latch_to_strobe", 32'(cyc - lat_cyc), 32'd137);
        check("clk_pulses", 32'(falls), 32'd16);
        in_frame = 1'b0;
      end
    end
    prev_latch = pad_latch;
    prev_clk   = pad_clk;
  end

  task automatic wait_strobe(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk_sys);
      if (frame_strobe) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_latch(input int maxc, output int at);
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk_sys);
      if (pad_latch) begin
        at = cyc;
        return;
      end
    end
  endtask

  task automatic wait_clk_low(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk_sys);
      if (!pad_clk) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pad_clk"}, 32'(pad_clk), 32'd1);
    check({tag, "_pad_latch"}, 32'(pad_latch), 32'd0);
    check({tag, "_strobe"}, 32'(frame_strobe), 32'd0);
    check({tag, "_key"}, cont_key, 32'h0);
    check({tag, "_joy"}, cont_joy, 32'h8080_8080);
  endtask

  initial begin
    bit          ok;
    int          at, rel, rises;
    logic [31:0] saved;

    next_pressed = 16'h0009;  // B + Start
    repeat (3) @(negedge clk_sys);
    check_reset_values("reset");

    reset_n = 1'b1;
    rel     = cyc;
    wait_latch(400, at);
    check("first_latch_delay", 32'(at - rel), 32'd200);
    wait_strobe(300, ok);
    check("b_start_strobe_seen", 32'(ok), 32'd1);
    check("b_start_key", cont_key, 32'h3000_8020);
    @(negedge clk_sys);
    check("strobe_single_cycle", 32'(frame_strobe), 32'd0);

    next_pressed = 16'h0090;  // Up + Right
    wait_strobe(500, ok);
    check("up_right_strobe_seen", 32'(ok), 32'd1);
`ifdef SNAC_PAD_ANALOG_EN
    check("up_right_joy", cont_joy, 32'h8080_00FF);
`else
    check("up_right_joy", cont_joy, 32'h8080_8080);
`endif
    check("up_right_key", cont_key, 32'h3000_0009);

    next_pressed = 16'h00C0;  // Left + Right
    wait_strobe(500, ok);
    check("left_right_strobe_seen", 32'(ok), 32'd1);
    check("left_right_lx", 32'(cont_joy[7:0]), 32'h80);
    check("left_right_key", cont_key, 32'h3000_000C);

    for (int f = 0; f < 10; f++) begin
      next_pressed = 16'($urandom);
      wait_strobe(500, ok);
      check("random_strobe_seen", 32'(ok), 32'd1);
      check("random_key", cont_key, model_key(next_pressed));
    end

    // enable low across three poll periods while idle
    enable = 1'b0;
    saved  = cont_key;
    rises  = 0;
    for (int i = 0; i < 3 * PD; i++) begin
      @(negedge clk_sys);
      if (pad_latch) rises++;
    end
    check("disabled_latches", 32'(rises), 32'd0);
    check("disabled_key_held", cont_key, saved);
    enable = 1'b1;

    // enable dropped mid-shift: frame still publishes
    next_pressed = 16'($urandom);
    wait_clk_low(500, ok);
    check("midshift_clk_low_seen", 32'(ok), 32'd1);
    enable = 1'b0;
    wait_strobe(300, ok);
    check("midshift_strobe_seen", 32'(ok), 32'd1);
    check("midshift_key", cont_key, model_key(next_pressed));
    repeat (2 * PD) @(negedge clk_sys);
    enable = 1'b1;

    // reset pulsed during a LOW phase
    next_pressed = 16'h0F0F;
    wait_clk_low(500, ok);
    check("reset_test_clk_low_seen", 32'(ok), 32'd1);
    repeat (2) @(negedge clk_sys);
    #2 reset_n = 1'b0;
    #1 check_reset_values("midframe_reset");
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    rel     = cyc;
    wait_latch(400, at);
    check("post_reset_latch_delay", 32'(at - rel), 32'd200);
    wait_strobe(300, ok);
    check("post_reset_strobe_seen", 32'(ok), 32'd1);
    check("post_reset_key", cont_key, model_key(16'h0F0F));
    repeat (4) @(negedge clk_sys);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/snac_pad_encoder.md
# snac_pad_encoder

Polls an SNES-protocol controller on the SNAC port and packs the result into the Pocket `cont_key`/`cont_joy` 32-bit word format. It writes the same words that the joypad receiver consumes. It sits between the SNAC pins and the core's joypad block, acting as an alternative source to the APF bridge controller words. It drives the pad latch and clock, shifts in 16 serial bits, then publishes one coherent key word per poll frame.

## Interface
- `HALF_DIV`, 16'd400: clk_sys cycles per pad-clock half period; must be ≥ 4.
- `POLL_DIV`, 24'd1_237_500: clk_sys cycles between poll starts (≈60 Hz at 74.25 MHz).
- `clk_sys`  in  1  single system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  permits new poll frames.
- `pad_data`  in  1  serial data from the pad; asynchronous; active-low (0 = pressed).
- `pad_latch`  out  1  latch strobe to the pad.
- `pad_clk`  out  1  shift clock to the pad; idles high.
- `cont_key`  out  32  packed buttons; pad type in [31:28].
- `cont_joy`  out  32  packed analog word {ry, rx, ly, lx}.
- `frame_strobe`  out  1  one-cycle pulse when `cont_key`/`cont_joy` update.

## Operation
- Reset values:
  - `pad_latch`=0, `pad_clk`=1, `frame_strobe`=0.
  - `cont_key`=32'h0.
  - `cont_joy`=32'h8080_8080.
  - Poll counter=0; FSM in IDLE.
- `pad_data` passes through a 2-flop synchronizer before any use.
- Poll counter free-runs from 0 to POLL_DIV-1 and wraps. On the wrap cycle, IDLE goes to LATCH only if `enable`=1. A wrap that occurs while not in IDLE is dropped.
- FSM states:
  - IDLE.
  - LATCH: `pad_latch`=1 for 2·HALF_DIV cycles.
  - LOW: `pad_clk`=0 for HALF_DIV cycles. The synced data bit is sampled into `shift[k]` on the last LOW cycle.
  - HIGH: `pad_clk`=1 for HALF_DIV cycles. Then k++; go to LOW while k<16, else DONE.
  - DONE: one cycle. Registers the outputs, pulses `frame_strobe`, then returns to IDLE.
- Bit order k=0..15 is B, Y, Select, Start, Up, Down, Left, Right, A, X, L, R, ID0..ID3. ID bits are ignored.
- Packing (pressed = ~shift[k]):
  - [0] Up, [1] Down, [2] Left, [3] Right.
  - [4] A, [5] B, [6] X, [7] Y.
  - [8] L → l1, [9] R → r1; [13:10]=0.
  - [14] Select, [15] Start.
  - [27:16]=0; [31:28]=PAD_TYPE_SNAC (4'h3).
- `cont_key` and `cont_joy` change only in DONE, so consumers never see a partial frame.
- `enable` deasserted mid-frame: the current frame completes and publishes; no new frame starts.
- Reset mid-frame: all outputs return to reset values immediately. The partial frame is discarded. The first latch comes after a full POLL_DIV period following release.

## Timing
- Latch pulse width: 2·HALF_DIV cycles.
- Pad-clock period: 2·HALF_DIV cycles; 16 low pulses per frame.
- Frame length: LATCH start to DONE = 2·HALF_DIV + 32·HALF_DIV cycles, plus 1 for DONE.
- Sampled pin value lags the pin by 2 cycles (synchronizer). HALF_DIV ≥ 4 guarantees the settled value is captured.
- `frame_strobe` is high for exactly 1 cycle per completed frame, coincident with the new output values.
- Outputs are registered; no combinational path from `pad_data`.

## Configuration
- `SNAC_PAD_ANALOG_EN` defined: `cont_joy` mirrors the D-pad so that the receiver's analog-to-DPAD path also responds.
  - lx = 8'h00 for Left, 8'hFF for Right, 8'h80 otherwise.
  - ly = 8'h00 for Up, 8'hFF for Down, 8'h80 otherwise.
  - If both opposite directions are pressed, the axis is 8'h80.
  - rx and ry = 8'h80.
- Not defined: `cont_joy` is constant 32'h8080_8080.

## Structure
- Package `snac_pad_pkg` holds:
  - state enum {IDLE, LATCH, LOW, HIGH, DONE};
  - SNES bit-index constants;
  - `PAD_TYPE_SNAC`=4'h3;
  - `JOY_CENTER`=8'h80;
  - `cont_key` bit-position constants.
- One sub-module, `snac_sync`: 2-flop synchronizer with async active-low reset, reset value 1 (pad released).
- The half-period counter and poll counter stay inline.

## Test plan
All scenarios use HALF_DIV=4 and POLL_DIV=200.
- Reset asserted → `pad_clk`=1, `pad_latch`=0, `cont_key`=0, `cont_joy`=32'h8080_8080, `frame_strobe`=0.
- Pad model drives B and Start pressed (raw bits 0 and 3 low) → after DONE, `cont_key`=32'h3000_8020 and one `frame_strobe` pulse.
- Frame shape → `pad_latch` high for 8 cycles, 16 `pad_clk` low pulses of 4 cycles each, DONE 137 cycles after LATCH entry.
- `enable`=0 for 3 poll periods → no latch pulses, `cont_key` held. Deassert mid-SHIFT → that frame still publishes.
- Up+Right pressed → `cont_joy`=32'h8080_00FF with `SNAC_PAD_ANALOG_EN`, 32'h8080_8080 without. Left+Right pressed → lx=8'h80.
- `reset_n` pulsed low during LOW → `pad_clk`=1 immediately, no `frame_strobe`, next latch 200 cycles after release.
